// File: rtl/result_serializer.sv
// Captures the wide mod_exp result on a finish rise and streams it LSB-first
// as OUT_W-bit beats over valid/ready, flagging any word that had to be dropped.
module result_serializer #(
  parameter int WIDTH = 256,
  parameter int OUT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 finish,
  input  logic [2*WIDTH-1:0]   result,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clear_overrun
);

  localparam int RW    = 2 * WIDTH;
  localparam int BEATS = RW / OUT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic             ONE_BEAT = (BEATS == 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [RW-1:0]    shift_reg;
  logic [CNT_W-1:0] beat_cnt;
  logic             finish_q;

  logic rise, xfer, at_last, last_xfer;

  assign rise      = finish & ~finish_q;
  assign at_last   = (beat_cnt == LAST_CNT);
  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & at_last;

  // The current beat always sits in the low slice; each transfer shifts down.
  assign out_data = shift_reg[OUT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      beat_cnt  <= '0;
      finish_q  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      finish_q <= finish;

      // A rise is only lost if it cannot be chained onto the final beat.
      if (rise && (state == SEND) && !last_xfer)
        overrun <= 1'b1;
      else if (clear_overrun)
        overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (rise) begin
            shift_reg <= result;
            beat_cnt  <= '0;
            state     <= SEND;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_last  <= ONE_BEAT;
          end
        end
        SEND: begin
          if (xfer) begin
            if (at_last) begin
              if (rise) begin
                // Back-to-back word: reload without a bubble.
                shift_reg <= result;
                beat_cnt  <= '0;
                out_last  <= ONE_BEAT;
              end else begin
                shift_reg <= '0;
                beat_cnt  <= '0;
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                out_last  <= 1'b0;
              end
            end else begin
              shift_reg <= shift_reg >> OUT_W;
              beat_cnt  <= beat_cnt + CNT_W'(1);
              out_last  <= (beat_cnt == LAST_CNT - CNT_W'(1));
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench: a small 4-beat instance for directed protocol cases and a
// default-size instance for full-width LSB-first reassembly.
module tb_result_serializer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // small instance: WIDTH=8, OUT_W=4
  logic        s_finish = 1'b0, s_ready = 1'b0, s_clr = 1'b0;
  logic [15:0] s_result = '0;
  logic [3:0]  s_data;
  logic        s_valid, s_last, s_busy, s_ovr;

  result_serializer #(.WIDTH(8), .OUT_W(4)) u_small (
    .clk(clk), .reset(reset), .finish(s_finish), .result(s_result),
    .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready),
    .out_last(s_last), .busy(s_busy), .overrun(s_ovr), .clear_overrun(s_clr)
  );

  // default instance: WIDTH=256, OUT_W=8
  logic         b_finish = 1'b0, b_ready = 1'b0, b_clr = 1'b0;
  logic [511:0] b_result = '0;
  logic [7:0]   b_data;
  logic         b_valid, b_last, b_busy, b_ovr;

  result_serializer u_big (
    .clk(clk), .reset(reset), .finish(b_finish), .result(b_result),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
    .out_last(b_last), .busy(b_busy), .overrun(b_ovr), .clear_overrun(b_clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard entries are {last, data}
  logic [4:0] exp_q[$];

  task automatic push_beat(input logic [3:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int k = 0; k < 4; k++) push_beat(w[k*4 +: 4], k == 3);
  endtask

  // small monitor: pops on every transfer and checks stall stability
  logic       stall_q = 1'b0;
  logic [3:0] stall_d;
  logic       stall_l;
  always @(negedge clk) begin
    if (!reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", s_valid, 1'b1);
        check("stall_data", s_data, stall_d);
        check("stall_last", s_last, stall_l);
      end
      if (s_valid && s_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data=%0h last=%0b expected no beat", s_data, s_last);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          check("beat_data", s_data, e[3:0]);
          check("beat_last", s_last, e[4]);
        end
      end
      stall_q = s_valid && !s_ready;
      stall_d = s_data;
      stall_l = s_last;
    end
  end

  // big monitor: reassembles beats and checks out_last position
  int           b_cnt = 0;
  logic [511:0] b_got = '0;
  always @(negedge clk) begin
    if (reset && b_valid && b_ready) begin
      if (b_cnt < 64) begin
        b_got[b_cnt*8 +: 8] = b_data;
        check("big_last", b_last, b_cnt == 63);
      end
      b_cnt++;
    end
  end

  initial begin
    // reset held
    tick(); tick();
    check("rst_valid", s_valid, 1'b0);
    check("rst_busy", s_busy, 1'b0);
    check("rst_ovr", s_ovr, 1'b0);
    check("rst_data", s_data, 4'h0);
    check("rst_last", s_last, 1'b0);
    reset = 1'b1;
    tick();

    // basic word, ready always high
    s_ready = 1'b1;
    push_word(16'hA5C3);
    s_finish = 1'b1; s_result = 16'hA5C3;
    check("lat_pre_valid", s_valid, 1'b0);
    tick();
    check("lat_valid", s_valid, 1'b1);
    check("lat_busy", s_busy, 1'b1);
    s_finish = 1'b0;
    repeat (4) tick();
    check("basic_idle_valid", s_valid, 1'b0);
    check("basic_idle_busy", s_busy, 1'b0);
    check("basic_q_empty", exp_q.size(), 0);

    // backpressure pattern 1,0,0,1,0,1,1
    begin
      logic [6:0] pat;
      pat = 7'b1101001; // bit i is ready in SEND cycle i
      push_word(16'hA5C3);
      s_ready = 1'b0; s_finish = 1'b1;
      tick();
      s_finish = 1'b0;
      for (int i = 0; i < 7; i++) begin
        s_ready = pat[i];
        tick();
      end
      check("bp_idle_valid", s_valid, 1'b0);
      check("bp_q_empty", exp_q.size(), 0);
      s_ready = 1'b1;
    end

    // overrun: rise during beat 2 is dropped
    push_word(16'hA5C3);
    s_finish = 1'b1; s_result = 16'hA5C3;
    tick(); s_finish = 1'b0;
    tick();
    tick(); s_finish = 1'b1; s_result = 16'h1234;
    tick();
    check("ovr_set", s_ovr, 1'b1);
    tick();
    check("ovr_sticky", s_ovr, 1'b1);
    check("ovr_idle_valid", s_valid, 1'b0);
    s_finish = 1'b0;
    tick();
    push_word(16'hA5C3);
    s_finish = 1'b1; s_result = 16'hA5C3;
    tick(); s_finish = 1'b0;
    tick(); s_finish = 1'b1; s_result = 16'h1234; s_clr = 1'b1;
    tick();
    check("ovr_set_wins", s_ovr, 1'b1);
    s_clr = 1'b0; s_finish = 1'b0;
    tick(); tick();
    s_clr = 1'b1;
    tick();
    check("ovr_cleared", s_ovr, 1'b0);
    s_clr = 1'b0;
    check("ovr_q_empty", exp_q.size(), 0);

    // back-to-back: rise coincides with final-beat transfer
    push_word(16'hA5C3);
    push_word(16'h0F1E);
    s_finish = 1'b1; s_result = 16'hA5C3;
    tick(); s_finish = 1'b0;
    tick(); tick(); tick();
    check("b2b_at_last", s_last, 1'b1);
    s_finish = 1'b1; s_result = 16'h0F1E;
    tick();
    check("b2b_no_bubble", s_valid, 1'b1);
    check("b2b_first_data", s_data, 4'hE);
    s_result = 16'hFFFF;
    repeat (4) tick();
    check("b2b_idle", s_valid, 1'b0);
    check("b2b_no_ovr", s_ovr, 1'b0);
    check("b2b_q_empty", exp_q.size(), 0);
    s_finish = 1'b0;
    tick();

    // finish held high for 10 cycles -> one word
    push_word(16'hA5C3);
    s_finish = 1'b1; s_result = 16'hA5C3;
    repeat (10) tick();
    check("held_idle", s_valid, 1'b0);
    check("held_q_empty", exp_q.size(), 0);
    s_finish = 1'b0;
    tick();

    // async reset after two beats
    push_beat(4'h3, 1'b0);
    push_beat(4'hC, 1'b0);
    s_finish = 1'b1;
    tick(); s_finish = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("arst_valid", s_valid, 1'b0);
    check("arst_busy", s_busy, 1'b0);
    check("arst_data", s_data, 4'h0);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    check("post_rst_valid", s_valid, 1'b0);
    check("post_rst_busy", s_busy, 1'b0);
    check("arst_q_empty", exp_q.size(), 0);

    // default-size instance, random 512-bit word
    for (int i = 0; i < 16; i++) b_result[i*32 +: 32] = $urandom();
    b_ready = 1'b1;
    b_finish = 1'b1;
    tick();
    b_finish = 1'b0;
    begin
      int n;
      n = 0;
      while (b_busy && n < 200) begin
        tick();
        n++;
      end
      check("big_timeout", n < 200, 1'b1);
    end
    tick();
    check("big_beats", b_cnt, 64);
    check("big_reassembly", b_got, b_result);
    check("big_ovr", b_ovr, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
